// File: rtl/frame_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_cmd_ctrl
// Description : Byte-framed command controller. Decodes command frames from
//               an RX byte stream and drives register writes/reads, burst
//               reads, and ALU operations, pushing results into a TX FIFO.
//               All outputs are registered.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               rx_data/rx_vld     - received byte and its one-cycle strobe
//               reg_rd_data/_vld   - register read return path
//               alu_out/alu_vld    - ALU result return path
//               fifo_full          - TX FIFO back-pressure
//               fifo_wr_inc/_data  - TX FIFO push strobe and word
//               reg_wr_en/rd_en, reg_addr, reg_wr_data - register file port
//               alu_op, alu_en, gate_en, clkdiv_en     - ALU / clock control
//               busy, err_cmd, err_timeout             - status
// Revision    : 1.0 - initial release
// ============================================================================
module frame_cmd_ctrl #(
    parameter int DW      = 8,
    parameter int AW      = 4,
    parameter int RW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_vld,
    input  logic [DW-1:0] reg_rd_data,
    input  logic          reg_rd_vld,
    input  logic [RW-1:0] alu_out,
    input  logic          alu_vld,
    input  logic          fifo_full,
    output logic          fifo_wr_inc,
    output logic [DW-1:0] fifo_wr_data,
    output logic          reg_wr_en,
    output logic          reg_rd_en,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wr_data,
    output logic [3:0]    alu_op,
    output logic          alu_en,
    output logic          gate_en,
    output logic          clkdiv_en,
    output logic          busy,
    output logic          err_cmd,
    output logic          err_timeout
);

    localparam int c_NB = RW / DW;
    localparam int c_IW = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(c_NB - 1);

    localparam logic [DW-1:0] c_CMD_WR  = DW'(8'hAA);
    localparam logic [DW-1:0] c_CMD_RD  = DW'(8'hBB);
    localparam logic [DW-1:0] c_CMD_BR  = DW'(8'hEE);
    localparam logic [DW-1:0] c_CMD_ALU = DW'(8'hCC);
    localparam logic [DW-1:0] c_CMD_FUN = DW'(8'hDD);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] c_ST_WR_DATA  = 4'd2;
    localparam logic [3:0] c_ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] c_ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] c_ST_RD_PUSH  = 4'd5;
    localparam logic [3:0] c_ST_BR_ADDR  = 4'd6;
    localparam logic [3:0] c_ST_BR_CNT   = 4'd7;
    localparam logic [3:0] c_ST_ALU_A    = 4'd8;
    localparam logic [3:0] c_ST_ALU_B    = 4'd9;
    localparam logic [3:0] c_ST_ALU_FUN  = 4'd10;
    localparam logic [3:0] c_ST_ALU_WAIT = 4'd11;
    localparam logic [3:0] c_ST_ALU_PUSH = 4'd12;

    logic [3:0]      r_state, w_state;
    logic [c_TW-1:0] r_tmo_cnt, w_tmo_cnt;
    logic [AW-1:0]   r_br_addr, w_br_addr;    // next burst address
    logic [DW-1:0]   r_br_rem, w_br_rem;      // burst reads still to issue
    logic [DW-1:0]   r_rd_word, w_rd_word;
    logic [RW-1:0]   r_alu_res, w_alu_res;    // shifted right one word per push
    logic [c_IW-1:0] r_idx, w_idx;
    logic            r_fifo_wr_inc, w_fifo_wr_inc;
    logic [DW-1:0]   r_fifo_wr_data, w_fifo_wr_data;
    logic            r_reg_wr_en, w_reg_wr_en;
    logic            r_reg_rd_en, w_reg_rd_en;
    logic [AW-1:0]   r_reg_addr, w_reg_addr;
    logic [DW-1:0]   r_reg_wr_data, w_reg_wr_data;
    logic [3:0]      r_alu_op, w_alu_op;
    logic            r_alu_en, w_alu_en;
    logic            r_gate_en, w_gate_en;
    logic            r_clkdiv_en;
    logic            r_busy, w_busy;
    logic            r_err_cmd, w_err_cmd;
    logic            r_err_timeout, w_err_timeout;
    logic            w_timed, w_expire;

    always_comb begin
        w_state        = r_state;
        w_br_addr      = r_br_addr;
        w_br_rem       = r_br_rem;
        w_rd_word      = r_rd_word;
        w_alu_res      = r_alu_res;
        w_idx          = r_idx;
        w_fifo_wr_inc  = 1'b0;
        w_fifo_wr_data = r_fifo_wr_data;
        w_reg_wr_en    = 1'b0;
        w_reg_rd_en    = 1'b0;
        w_reg_addr     = r_reg_addr;
        w_reg_wr_data  = r_reg_wr_data;
        w_alu_op       = r_alu_op;
        w_err_cmd      = 1'b0;
        w_err_timeout  = 1'b0;

        // Only states waiting on the next frame byte are subject to timeout.
        w_timed = (r_state == c_ST_WR_ADDR) || (r_state == c_ST_WR_DATA) ||
                  (r_state == c_ST_RD_ADDR) || (r_state == c_ST_BR_ADDR) ||
                  (r_state == c_ST_BR_CNT)  || (r_state == c_ST_ALU_A)   ||
                  (r_state == c_ST_ALU_B)   || (r_state == c_ST_ALU_FUN);
        // A byte arriving on the expiry cycle wins over the timeout.
        w_expire  = w_timed && !rx_vld && (TIMEOUT != 0) && (r_tmo_cnt == c_TMO_LAST);
        w_tmo_cnt = (rx_vld || !w_timed || w_expire) ? '0 : r_tmo_cnt + 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                if (rx_vld) begin
                    case (rx_data)
                        c_CMD_WR:  w_state = c_ST_WR_ADDR;
                        c_CMD_RD:  w_state = c_ST_RD_ADDR;
                        c_CMD_BR:  w_state = c_ST_BR_ADDR;
                        c_CMD_ALU: w_state = c_ST_ALU_A;
                        c_CMD_FUN: w_state = c_ST_ALU_FUN;
                        default:   w_err_cmd = 1'b1;
                    endcase
                end
            end
            c_ST_WR_ADDR, c_ST_WR_DATA, c_ST_RD_ADDR, c_ST_BR_ADDR,
            c_ST_BR_CNT, c_ST_ALU_A, c_ST_ALU_B, c_ST_ALU_FUN: begin
                if (rx_vld) begin
                    case (r_state)
                        c_ST_WR_ADDR: begin
                            w_reg_addr = rx_data[AW-1:0];
                            w_state    = c_ST_WR_DATA;
                        end
                        c_ST_WR_DATA: begin
                            w_reg_wr_en   = 1'b1;
                            w_reg_wr_data = rx_data;
                            w_state       = c_ST_IDLE;
                        end
                        c_ST_RD_ADDR: begin
                            w_reg_rd_en = 1'b1;
                            w_reg_addr  = rx_data[AW-1:0];
                            w_br_rem    = '0;
                            w_state     = c_ST_RD_WAIT;
                        end
                        c_ST_BR_ADDR: begin
                            w_br_addr = rx_data[AW-1:0];
                            w_state   = c_ST_BR_CNT;
                        end
                        c_ST_BR_CNT: begin
                            if (rx_data == '0) begin
                                w_state = c_ST_IDLE;
                            end else begin
                                w_reg_rd_en = 1'b1;
                                w_reg_addr  = r_br_addr;
                                w_br_addr   = r_br_addr + 1'b1;
                                w_br_rem    = rx_data - 1'b1;
                                w_state     = c_ST_RD_WAIT;
                            end
                        end
                        c_ST_ALU_A, c_ST_ALU_B: begin
                            w_reg_wr_en   = 1'b1;
                            w_reg_addr    = (r_state == c_ST_ALU_A) ? AW'(0) : AW'(1);
                            w_reg_wr_data = rx_data;
                            w_state       = (r_state == c_ST_ALU_A) ? c_ST_ALU_B : c_ST_ALU_FUN;
                        end
                        default: begin
                            w_alu_op = rx_data[3:0];
                            w_state  = c_ST_ALU_WAIT;
                        end
                    endcase
                end else if (w_expire) begin
                    w_err_timeout = 1'b1;
                    w_state       = c_ST_IDLE;
                end
            end
            c_ST_RD_WAIT: begin
                if (reg_rd_vld) begin
                    w_rd_word = reg_rd_data;
                    w_state   = c_ST_RD_PUSH;
                end
            end
            c_ST_RD_PUSH: begin
                if (!fifo_full) begin
                    w_fifo_wr_inc  = 1'b1;
                    w_fifo_wr_data = r_rd_word;
                    if (r_br_rem != '0) begin
                        w_reg_rd_en = 1'b1;
                        w_reg_addr  = r_br_addr;
                        w_br_addr   = r_br_addr + 1'b1;
                        w_br_rem    = r_br_rem - 1'b1;
                        w_state     = c_ST_RD_WAIT;
                    end else begin
                        w_state = c_ST_IDLE;
                    end
                end
            end
            c_ST_ALU_WAIT: begin
                if (alu_vld) begin
                    w_alu_res = alu_out;
                    w_idx     = '0;
                    w_state   = c_ST_ALU_PUSH;
                end
            end
            c_ST_ALU_PUSH: begin
                if (!fifo_full) begin
                    w_fifo_wr_inc  = 1'b1;
                    w_fifo_wr_data = r_alu_res[DW-1:0];
                    w_alu_res      = r_alu_res >> DW;
                    w_idx          = r_idx + 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state = c_ST_IDLE;
                    end
                end
            end
            default: w_state = c_ST_IDLE;
        endcase

        // Level outputs follow the next state; gate_en also covers the cycle
        // in which the final ALU word is presented to the FIFO.
        w_alu_en  = (w_state == c_ST_ALU_WAIT);
        w_gate_en = (w_state == c_ST_ALU_WAIT) || (w_state == c_ST_ALU_PUSH) ||
                    (r_state == c_ST_ALU_PUSH);
        w_busy    = (w_state != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_tmo_cnt      <= '0;
            r_br_addr      <= '0;
            r_br_rem       <= '0;
            r_rd_word      <= '0;
            r_alu_res      <= '0;
            r_idx          <= '0;
            r_fifo_wr_inc  <= 1'b0;
            r_fifo_wr_data <= '0;
            r_reg_wr_en    <= 1'b0;
            r_reg_rd_en    <= 1'b0;
            r_reg_addr     <= '0;
            r_reg_wr_data  <= '0;
            r_alu_op       <= '0;
            r_alu_en       <= 1'b0;
            r_gate_en      <= 1'b0;
            r_clkdiv_en    <= 1'b1;
            r_busy         <= 1'b0;
            r_err_cmd      <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_tmo_cnt      <= w_tmo_cnt;
            r_br_addr      <= w_br_addr;
            r_br_rem       <= w_br_rem;
            r_rd_word      <= w_rd_word;
            r_alu_res      <= w_alu_res;
            r_idx          <= w_idx;
            r_fifo_wr_inc  <= w_fifo_wr_inc;
            r_fifo_wr_data <= w_fifo_wr_data;
            r_reg_wr_en    <= w_reg_wr_en;
            r_reg_rd_en    <= w_reg_rd_en;
            r_reg_addr     <= w_reg_addr;
            r_reg_wr_data  <= w_reg_wr_data;
            r_alu_op       <= w_alu_op;
            r_alu_en       <= w_alu_en;
            r_gate_en      <= w_gate_en;
            r_clkdiv_en    <= 1'b1;
            r_busy         <= w_busy;
            r_err_cmd      <= w_err_cmd;
            r_err_timeout  <= w_err_timeout;
        end
    end

    assign fifo_wr_inc  = r_fifo_wr_inc;
    assign fifo_wr_data = r_fifo_wr_data;
    assign reg_wr_en    = r_reg_wr_en;
    assign reg_rd_en    = r_reg_rd_en;
    assign reg_addr     = r_reg_addr;
    assign reg_wr_data  = r_reg_wr_data;
    assign alu_op       = r_alu_op;
    assign alu_en       = r_alu_en;
    assign gate_en      = r_gate_en;
    assign clkdiv_en    = r_clkdiv_en;
    assign busy         = r_busy;
    assign err_cmd      = r_err_cmd;
    assign err_timeout  = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_frame_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_frame_cmd_ctrl
// Description : Self-checking bench for frame_cmd_ctrl. Expected register
//               writes, reads and FIFO pushes are queued per frame and matched
//               against the DUT every cycle; register file and ALU are modelled
//               as simple responders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_cmd_ctrl;

    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int RW      = 16;
    localparam int TMO     = 255;
    localparam int NB      = RW / DW;
    localparam int RD_LAT  = 2;
    localparam int ALU_LAT = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx_data;
    logic          rx_vld;
    logic [DW-1:0] reg_rd_data;
    logic          reg_rd_vld;
    logic [RW-1:0] alu_out;
    logic          alu_vld;
    logic          fifo_full;
    logic          fifo_wr_inc;
    logic [DW-1:0] fifo_wr_data;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wr_data;
    logic [3:0]    alu_op;
    logic          alu_en;
    logic          gate_en;
    logic          clkdiv_en;
    logic          busy;
    logic          err_cmd;
    logic          err_timeout;

    frame_cmd_ctrl #(.DW(DW), .AW(AW), .RW(RW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_vld(rx_vld),
        .reg_rd_data(reg_rd_data), .reg_rd_vld(reg_rd_vld),
        .alu_out(alu_out), .alu_vld(alu_vld),
        .fifo_full(fifo_full),
        .fifo_wr_inc(fifo_wr_inc), .fifo_wr_data(fifo_wr_data),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
        .alu_op(alu_op), .alu_en(alu_en), .gate_en(gate_en),
        .clkdiv_en(clkdiv_en), .busy(busy),
        .err_cmd(err_cmd), .err_timeout(err_timeout)
    );

    initial forever #5 clk = ~clk;

    // Expected-event model: {addr,data} writes, read addresses, pushed words.
    logic [11:0] q_wr[$];
    logic [3:0]  q_rd[$];
    logic [7:0]  q_push[$];
    logic [7:0]  mem [16];
    logic [3:0]  exp_alu_op = 4'h0;
    logic [15:0] alu_result = 16'h0;
    logic [3:0]  rd_a;
    int n_pass = 0;
    int n_total = 0;
    int obs_cmd = 0;
    int obs_tmo = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic extra(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: got unexpected event 0x%0h, required none (t=%0t)", name, act, $time);
    endtask

    // Compare process: every cycle, 1ns after the edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                chk("reset_ctrl", {19'd0, reg_wr_en, reg_rd_en, fifo_wr_inc, alu_en, gate_en,
                                   busy, err_cmd, err_timeout, clkdiv_en, alu_op}, 32'h10);
                chk("reset_data", {12'd0, reg_addr, reg_wr_data, fifo_wr_data}, 32'h0);
            end else begin
                chk("clkdiv_en", clkdiv_en, 1);
                if (reg_wr_en) begin
                    if (q_wr.size() == 0) extra("reg_write", {reg_addr, reg_wr_data});
                    else chk("reg_write", {reg_addr, reg_wr_data}, q_wr.pop_front());
                end
                if (reg_rd_en) begin
                    if (q_rd.size() == 0) extra("reg_read", reg_addr);
                    else chk("reg_read_addr", reg_addr, q_rd.pop_front());
                end
                if (fifo_wr_inc) begin
                    chk("push_while_full", fifo_full, 0);
                    if (q_push.size() == 0) extra("fifo_push", fifo_wr_data);
                    else chk("fifo_push_data", fifo_wr_data, q_push.pop_front());
                end
                if (alu_en) begin
                    chk("alu_op", alu_op, exp_alu_op);
                    chk("gate_with_alu_en", gate_en, 1);
                end
                if (err_cmd) obs_cmd++;
                if (err_timeout) obs_tmo++;
            end
        end
    end

    // Register file read responder.
    initial begin
        reg_rd_vld  = 1'b0;
        reg_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (reg_rd_en && !rst) begin
                rd_a = reg_addr;
                repeat (RD_LAT) @(negedge clk);
                reg_rd_data = mem[rd_a];
                reg_rd_vld  = 1'b1;
                @(negedge clk);
                reg_rd_vld  = 1'b0;
            end
        end
    end

    // ALU responder.
    initial begin
        alu_vld = 1'b0;
        alu_out = '0;
        forever begin
            @(posedge clk); #1;
            if (alu_en && !rst) begin
                repeat (ALU_LAT) @(negedge clk);
                alu_out = alu_result;
                alu_vld = 1'b1;
                @(negedge clk);
                alu_vld = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
    endtask

    task automatic done(input string name, input int e_cmd, input int e_tmo);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (!busy && q_wr.size() == 0 && q_rd.size() == 0 && q_push.size() == 0) break;
        end
        repeat (4) @(posedge clk);
        #2;
        chk({name, "_busy"}, busy, 0);
        chk({name, "_writes_left"}, q_wr.size(), 0);
        chk({name, "_reads_left"}, q_rd.size(), 0);
        chk({name, "_pushes_left"}, q_push.size(), 0);
        chk({name, "_err_cmd_cnt"}, obs_cmd, e_cmd);
        chk({name, "_err_tmo_cnt"}, obs_tmo, e_tmo);
        obs_cmd = 0;
        obs_tmo = 0;
        q_wr.delete();
        q_rd.delete();
        q_push.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1);
    end

    initial begin
        int a;
        int k;
        rst       = 1'b1;
        rx_vld    = 1'b0;
        rx_data   = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17 + 3);
        mem[7] = 8'h5A;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_clkdiv", clkdiv_en, 1);

        // Single write.
        q_wr.push_back({4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        done("write", 0, 0);

        // Single read; a byte during RD_WAIT is discarded.
        q_rd.push_back(4'h7);
        q_push.push_back(8'h5A);
        send(8'hBB); send(8'h07); send(8'hBB);
        done("read", 0, 0);

        // Burst read wrapping at the top of the address space.
        q_rd.push_back(4'hE); q_rd.push_back(4'hF); q_rd.push_back(4'h0);
        q_push.push_back(8'hF1); q_push.push_back(8'h02); q_push.push_back(8'h03);
        send(8'hEE); send(8'h0E); send(8'h03);
        done("burst_wrap", 0, 0);

        // Zero-length burst.
        send(8'hEE); send(8'h03); send(8'h00);
        done("burst_zero", 0, 0);

        // Longer burst, expectations from address arithmetic.
        for (int j = 0; j < 7; j++) begin
            a = (11 + j) % 16;
            q_rd.push_back(4'(a));
            q_push.push_back(mem[a]);
        end
        send(8'hEE); send(8'h0B); send(8'h07);
        done("burst_model", 0, 0);

        // ALU frame with FIFO back-pressure during the push phase.
        exp_alu_op = 4'h1;
        alu_result = 16'h0030;
        q_wr.push_back({4'h0, 8'h10}); q_wr.push_back({4'h1, 8'h20});
        q_push.push_back(8'h30); q_push.push_back(8'h00);
        send(8'hCC); send(8'h10); send(8'h20); send(8'h01);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (fifo_wr_inc) break;
        end
        chk("alu_first_push_seen", fifo_wr_inc, 1);
        @(negedge clk);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("stall_no_push", fifo_wr_inc, 0);
            chk("stall_gate_en", gate_en, 1);
            chk("stall_busy", busy, 1);
        end
        @(negedge clk);
        fifo_full = 1'b0;
        @(posedge clk); #2;
        chk("resume_push", fifo_wr_inc, 1);
        chk("resume_data", fifo_wr_data, 8'h00);
        chk("last_push_gate_en", gate_en, 1);
        done("alu_backpressure", 0, 0);
        chk("alu_done_gate_en", gate_en, 0);
        chk("alu_done_alu_en", alu_en, 0);

        // DD shortcut; byte during ALU_WAIT discarded; pushes LSB first.
        exp_alu_op = 4'h7;
        alu_result = 16'hBEEF;
        for (int j = 0; j < NB; j++) q_push.push_back(8'(alu_result >> (8 * j)));
        send(8'hDD); send(8'h07); send(8'hAA);
        done("alu_dd", 0, 0);

        // Unknown command byte.
        send(8'h42);
        chk("err_cmd_pulse", err_cmd, 1);
        @(posedge clk); #2;
        chk("err_cmd_one_cycle", err_cmd, 0);
        done("bad_cmd", 1, 0);

        // Timeout after exactly TMO idle cycles.
        k = -1;
        send(8'hAA);
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #2;
            if (err_timeout) begin
                k = i;
                break;
            end
        end
        chk("timeout_cycles", k, TMO);
        chk("timeout_busy", busy, 0);
        done("timeout", 0, 1);

        // Byte arriving on the expiry cycle is accepted.
        q_wr.push_back({4'h5, 8'h3C});
        send(8'hAA);
        repeat (TMO - 2) @(negedge clk);
        send(8'h05); send(8'h3C);
        done("tmo_boundary", 0, 0);

        // Reset after the first ALU word abandons the second.
        exp_alu_op = 4'h3;
        alu_result = 16'hA55A;
        q_wr.push_back({4'h0, 8'h01}); q_wr.push_back({4'h1, 8'h02});
        q_push.push_back(8'h5A);
        send(8'hCC); send(8'h01); send(8'h02); send(8'h03);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (fifo_wr_inc) break;
        end
        chk("rst_first_push_seen", fifo_wr_inc, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("rst_no_push", fifo_wr_inc, 0);
        chk("rst_gate_en", gate_en, 0);
        @(negedge clk);
        rst = 1'b0;
        done("alu_reset", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
